bcd_score_to_binary: RTL and testbench
======================================

// Module: bcd_score_to_binary
//
// PURPOSE
//   Multi-cycle decimal-digit-to-binary converter: the inverse of the score digit splitter.
//   Accepts a packed set of per-digit score values (most significant digit = highest index)
//   and returns the binary score. One digit is processed per cycle as acc = acc*10 + digit.
//   Used where stored or displayed digit scores must be compared or added in binary
//   (high-score check, score restore). Valid/ready handshake on both sides.
//
// PARAMETERS
//   DIGITS  5   number of decimal digits in digits_in (>=1)
//   DIG_W   5   width of each digit field (matches score digit width)
//   BIN_W   17  width of binary result (5 digits: 99999 fits in 17 bits)
//
// PORTS
//   clk        in   1             rising-edge clock
//   resetn     in   1             asynchronous active-low reset
//   in_valid   in   1             digits_in valid
//   in_ready   out  1             block idle; can accept digits_in
//   digits_in  in   DIGITS*DIG_W  digit i at [i*DIG_W +: DIG_W]; digit 0 = ones place
//   out_valid  out  1             bin_out/err/ovf valid
//   out_ready  in   1             consumer accepts result
//   bin_out    out  BIN_W         binary value
//   err        out  1             at least one digit field > 9 in this conversion
//   ovf        out  1             result exceeded 2^BIN_W-1; bin_out saturated
//
// BEHAVIOUR
//   - resetn low (any time, async): state=IDLE, bin_out=0, err=0, ovf=0, out_valid=0, idx=0.
//     in_ready=0 while resetn low; 1 in IDLE otherwise.
//   - FSM: IDLE -> CONV -> DONE -> IDLE.
//   - IDLE: in_ready=1. On edge with in_valid=1: latch digits_in, acc=0, err=0, ovf=0,
//     idx=DIGITS-1, go CONV. in_valid with in_ready=0 is ignored (no queuing).
//   - CONV: in_ready=0, out_valid=0. Each edge: d = digit[idx]; if d>9 then err<=1, d=9.
//     tmp = acc*10 + d computed in BIN_W+4 bits. If tmp > 2^BIN_W-1 or ovf already set:
//     acc <= all ones, ovf <= 1. Else acc <= tmp. If idx==0 go DONE, else idx <= idx-1.
//   - Latency: out_valid rises exactly DIGITS edges after the accepting edge (DIGITS=5: 5).
//   - DONE: out_valid=1; bin_out=acc, err, ovf held stable while out_ready=0.
//     On edge with out_valid & out_ready: out_valid <= 0, go IDLE. in_ready rises the cycle
//     after; a result handoff and a new accept never share an edge (throughput 1/(DIGITS+2)).
//   - bin_out, err and ovf keep their last values in IDLE until the next accept, which clears
//     err/ovf. Consumers sample them only when out_valid=1.
//   - Reset mid-CONV or mid-DONE discards the conversion; no partial result is presented.
//   - All outputs are registered. in_ready is decoded from the state register only.
//
// TESTING
//   1. Digits 1,2,3,4,5 (d4..d0), in_valid for 1 cycle -> 5 edges later out_valid=1,
//      bin_out=12345, err=0, ovf=0.
//   2. Digits 0,0,0,0,0 -> bin_out=0; digits 9,9,9,9,9 -> bin_out=99999 (17'h1869F), ovf=0.
//   3. Digits 1,2,11,4,5 -> err=1, bin_out=12945 (bad digit clamped to 9); the next clean
//      conversion 0,0,0,0,7 -> err=0, bin_out=7.
//   4. Hold out_ready=0 for 10 cycles in DONE and pulse in_valid with new digits -> out_valid,
//      bin_out and err stay stable, in_ready=0, new digits ignored. Raise out_ready -> IDLE;
//      in_ready=1 next cycle.
//   5. DIGITS=6, BIN_W=17, digits 9,9,9,9,9,9 -> ovf=1, bin_out=131071. Digits
//      1,3,1,0,7,1 -> bin_out=131071, ovf=0 (exact max, no overflow).
//   6. Assert resetn low on the 3rd CONV edge -> out_valid=0 and bin_out=0 immediately
//      (async). Release reset -> in_ready=1, and a fresh 12345 conversion completes correctly.

Source files
------------

// File: rtl/bcd_score_to_binary.sv
// Decimal digit set to binary score converter, one digit per cycle.
// Ports: clk/resetn, in_valid/in_ready/digits_in, out_valid/out_ready, bin_out/err/ovf.
module bcd_score_to_binary #(
    parameter int DIGITS = 5,
    parameter int DIG_W  = 5,
    parameter int BIN_W  = 17
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGITS*DIG_W-1:0] digits_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    err,
    output logic                    ovf
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TMP_W = BIN_W + 4;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);
    localparam logic [TMP_W-1:0] BIN_MAX = {4'b0, {BIN_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [DIGITS*DIG_W-1:0] dig_q;
    logic [BIN_W-1:0]        acc;
    logic [BIN_W-1:0]        acc_nxt;
    logic [IDX_W-1:0]        idx;
    logic [DIG_W-1:0]        dsel;
    logic                    dbad;
    logic [3:0]              dnib;
    logic [TMP_W-1:0]        tmp;
    logic                    sat;
    logic                    accept;
    logic                    last;

    // Digit datapath: clamp out-of-range digits to 9, then
    // acc*10+d in a widened sum so overflow is visible.
    always_comb begin
        dsel    = dig_q[idx*DIG_W +: DIG_W];
        dbad    = dsel > DIG_W'(9);
        dnib    = dbad ? 4'd9 : dsel[3:0];
        tmp     = TMP_W'(acc) * TMP_W'(10) + TMP_W'(dnib);
        sat     = ovf || (tmp > BIN_MAX);
        acc_nxt = sat ? {BIN_W{1'b1}} : tmp[BIN_W-1:0];
        last    = (idx == '0);
        accept  = (state == IDLE) && in_valid && in_ready;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (accept) state_d = CONV;
            CONV: if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state,
    // so in_ready stays low through reset and for one cycle after a handoff.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            dig_q     <= '0;
            acc       <= '0;
            idx       <= '0;
            bin_out   <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            if (accept) begin
                dig_q <= digits_in;
                acc   <= '0;
                err   <= 1'b0;
                ovf   <= 1'b0;
                idx   <= IDX_TOP;
            end
            if (state == CONV) begin
                acc <= acc_nxt;
                if (dbad) err <= 1'b1;
                if (sat) ovf <= 1'b1;
                if (last) bin_out <= acc_nxt;
                else idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_to_binary.sv
// Directed bench for bcd_score_to_binary (5-digit and 6-digit builds).
// Expected values are hand-computed decimal scores.
module tb_bcd_score_to_binary;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        in_valid5 = 1'b0;
    logic        in_ready5;
    logic [24:0] digits5 = '0;
    logic        out_valid5;
    logic        out_ready5 = 1'b0;
    logic [16:0] bin5;
    logic        err5;
    logic        ovf5;

    logic        in_valid6 = 1'b0;
    logic        in_ready6;
    logic [29:0] digits6 = '0;
    logic        out_valid6;
    logic        out_ready6 = 1'b0;
    logic [16:0] bin6;
    logic        err6;
    logic        ovf6;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_score_to_binary #(.DIGITS(5), .DIG_W(5), .BIN_W(17)) u5 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid5), .in_ready(in_ready5), .digits_in(digits5),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .bin_out(bin5), .err(err5), .ovf(ovf5)
    );

    bcd_score_to_binary #(.DIGITS(6), .DIG_W(5), .BIN_W(17)) u6 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid6), .in_ready(in_ready6), .digits_in(digits6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .bin_out(bin6), .err(err6), .ovf(ovf6)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] pk5(input int d4, d3, d2, d1, d0);
        return {5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    function automatic logic [29:0] pk6(input int d5, d4, d3, d2, d1, d0);
        return {5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    // Accept one digit set, wait a bounded number of edges for
    // out_valid, check latency and result, then hand it off.
    task automatic conv(input string tag, input bit six,
                        input logic [29:0] digs, input int exp_bin,
                        input int exp_err, input int exp_ovf);
        int n;
        @(negedge clk);
        chk({tag, "_rdy"}, six ? int'(in_ready6) : int'(in_ready5), 1);
        if (six) begin
            digits6 = digs; in_valid6 = 1'b1;
        end else begin
            digits5 = digs[24:0]; in_valid5 = 1'b1;
        end
        @(posedge clk); #1;
        in_valid5 = 1'b0; in_valid6 = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (six ? out_valid6 : out_valid5) begin
                n = i;
                break;
            end
        end
        chk({tag, "_lat"}, n, six ? 6 : 5);
        chk({tag, "_bin"}, six ? int'(bin6) : int'(bin5), exp_bin);
        chk({tag, "_err"}, six ? int'(err6) : int'(err5), exp_err);
        chk({tag, "_ovf"}, six ? int'(ovf6) : int'(ovf5), exp_ovf);
        @(negedge clk);
        out_ready5 = ~six; out_ready6 = six;
        @(posedge clk); #1;
        out_ready5 = 1'b0; out_ready6 = 1'b0;
        chk({tag, "_vld0"}, six ? int'(out_valid6) : int'(out_valid5), 0);
        chk({tag, "_rdy1"}, six ? int'(in_ready6) : int'(in_ready5), 1);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_vld", int'(out_valid5), 0);
        chk("rst_rdy", int'(in_ready5), 0);
        chk("rst_bin", int'(bin5), 0);
        chk("rst_err", int'(err5), 0);
        chk("rst_ovf", int'(ovf5), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rdy", int'(in_ready5), 1);

        conv("t1", 1'b0, 30'(pk5(1, 2, 3, 4, 5)), 12345, 0, 0);
        conv("t2a", 1'b0, 30'(pk5(0, 0, 0, 0, 0)), 0, 0, 0);
        conv("t2b", 1'b0, 30'(pk5(9, 9, 9, 9, 9)), 99999, 0, 0);
        conv("t3a", 1'b0, 30'(pk5(1, 2, 11, 4, 5)), 12945, 1, 0);
        conv("t3b", 1'b0, 30'(pk5(0, 0, 0, 0, 7)), 7, 0, 0);
        conv("t3c", 1'b0, 30'(pk5(31, 0, 0, 0, 0)), 90000, 1, 0);
        conv("t5a", 1'b1, pk6(9, 9, 9, 9, 9, 9), 131071, 0, 1);
        conv("t5b", 1'b1, pk6(1, 3, 1, 0, 7, 1), 131071, 0, 0);
        conv("t5c", 1'b1, pk6(1, 3, 1, 0, 7, 2), 131071, 0, 1);

        // Stall in DONE with out_ready low; a new in_valid pulse is ignored.
        @(negedge clk);
        digits5 = pk5(5, 4, 3, 2, 1); in_valid5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid5) begin
                n = i;
                break;
            end
        end
        chk("t4_lat", n, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                digits5 = pk5(1, 1, 1, 1, 1); in_valid5 = 1'b1;
            end else begin
                in_valid5 = 1'b0;
            end
            chk("t4_hold_vld", int'(out_valid5), 1);
            chk("t4_hold_bin", int'(bin5), 54321);
            chk("t4_hold_err", int'(err5), 0);
            chk("t4_hold_rdy", int'(in_ready5), 0);
        end
        @(negedge clk);
        in_valid5 = 1'b0; out_ready5 = 1'b1;
        @(posedge clk); #1;
        out_ready5 = 1'b0;
        chk("t4_vld0", int'(out_valid5), 0);
        chk("t4_rdy1", int'(in_ready5), 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid5) n++;
        end
        chk("t4_no_queue", n, 0);

        // Async reset in the middle of a conversion.
        @(negedge clk);
        digits5 = pk5(6, 7, 8, 9, 0); in_valid5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("t6_vld", int'(out_valid5), 0);
        chk("t6_bin", int'(bin5), 0);
        chk("t6_rdy", int'(in_ready5), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("t6_rdy1", int'(in_ready5), 1);
        chk("t6_vld_after", int'(out_valid5), 0);
        conv("t6c", 1'b0, 30'(pk5(1, 2, 3, 4, 5)), 12345, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
